lram_init_loader: RTL

LRAM_INIT_LOADER -- requirements
Module: lram_init_loader

---
 rtl/lram_init_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lram_init_loader.sv
// lram_init_loader
//   Streams DEPTH init words into a single-port LRAM (16K x 32 by default)
//   and keeps a running checksum of every accepted word. The optional verify
//   pass, enabled by defining LRAM_INIT_LOADER_VERIFY_EN, reads the whole
//   LRAM back and flags a mismatch between the readback sum and the checksum.
//
//   Ports
//     CLK       in   clock, rising edge
//     RSTN      in   asynchronous active-low reset
//     start     in   begin a load (honoured only in IDLE or DONE)
//     s_valid   in   init-word stream valid
//     s_data    in   init word
//     s_ready   out  stream ready (high in LOAD)
//     mem_ce    out  LRAM clock enable
//     mem_we    out  LRAM write enable
//     mem_ad    out  LRAM address
//     mem_di    out  LRAM write data
//     mem_do    in   LRAM read data, one cycle after a read request
//     busy      out  high in LOAD or VERIFY
//     done      out  high in DONE
//     error     out  readback mismatch, valid while done is high
//     checksum  out  modulo-2**DW sum of accepted words
//
//   Build option: LRAM_INIT_LOADER_VERIFY_EN adds the VERIFY state.
module lram_init_loader #(
  parameter int unsigned DEPTH = 16384,
  parameter int unsigned AW    = 14,
  parameter int unsigned DW    = 32
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [DW-1:0] checksum
);

`ifdef LRAM_INIT_LOADER_VERIFY_EN
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  localparam logic [AW-1:0] LAST_AD = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic          accept;
  logic          last_word;
  logic          start_ok;

  assign accept    = (state == LOAD) && s_valid;
  assign last_word = (cnt == LAST_AD);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

  assign s_ready = (state == LOAD);
  assign done    = (state == DONE);

`ifdef LRAM_INIT_LOADER_VERIFY_EN
  localparam logic [AW:0] VEND = (AW+1)'(DEPTH);

  logic [AW:0]   vcnt;
  logic [DW-1:0] rsum;
  logic          dv;
  logic          err_q;
  logic          mismatch;

  assign busy = (state == LOAD) || (state == VERIFY);

  // The last read's data lands in the first DONE cycle; the compare there
  // is combinational so error is valid as soon as done rises, then held.
  assign mismatch = ((rsum + mem_do) != checksum);
  assign error    = err_q | ((state == DONE) && dv && mismatch);
`else
  logic unused_do;

  assign busy      = (state == LOAD);
  assign error     = 1'b0;
  assign unused_do = ^mem_do;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
`ifdef LRAM_INIT_LOADER_VERIFY_EN
        if (accept && last_word) state_nxt = VERIFY;
`else
        if (accept && last_word) state_nxt = DONE;
`endif
      end
`ifdef LRAM_INIT_LOADER_VERIFY_EN
      VERIFY: begin
        if (vcnt == VEND) state_nxt = DONE;
      end
`endif
      DONE: begin
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port is registered: an accepted word is written the next cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt      <= '0;
      checksum <= '0;
      mem_ce   <= 1'b0;
      mem_we   <= 1'b0;
      mem_ad   <= '0;
      mem_di   <= '0;
    end else begin
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
      if (start_ok) begin
        cnt      <= '0;
        checksum <= '0;
      end else if (accept) begin
        mem_ce   <= 1'b1;
        mem_we   <= 1'b1;
        mem_ad   <= cnt;
        mem_di   <= s_data;
        checksum <= checksum + s_data;
        if (!last_word) cnt <= cnt + AW'(1);
      end
`ifdef LRAM_INIT_LOADER_VERIFY_EN
      // First VERIFY cycle carries the last write, so read 0 is issued
      // for the following cycle; reads never collide with a write.
      else if ((state == VERIFY) && (vcnt != VEND)) begin
        mem_ce <= 1'b1;
        mem_ad <= vcnt[AW-1:0];
      end
`endif
    end
  end

`ifdef LRAM_INIT_LOADER_VERIFY_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vcnt  <= '0;
      rsum  <= '0;
      dv    <= 1'b0;
      err_q <= 1'b0;
    end else if (start_ok) begin
      vcnt  <= '0;
      rsum  <= '0;
      dv    <= 1'b0;
      err_q <= 1'b0;
    end else begin
      // A read visible on the port now returns data next cycle.
      dv <= mem_ce & ~mem_we;
      if (dv) rsum <= rsum + mem_do;
      if ((state == VERIFY) && (vcnt != VEND)) vcnt <= vcnt + (AW+1)'(1);
      if ((state == DONE) && dv) err_q <= mismatch;
    end
  end
`endif

endmodule
